popcount_mac_serial: RTL



---
 rtl/popcount_mac_serial_if.sv | 31 +++
 rtl/popcount_mac_serial.sv | 131 +++++++++++++
 2 files changed

// File: rtl/popcount_mac_serial_if.sv
// Beat/result bundle for popcount_mac_serial: weight load, bit-plane stream in,
// signed dot-product result out.
interface popcount_mac_serial_if #(
    parameter int N     = 32,
    parameter int WBITS = 3,
    parameter int ACC_W = 18
);
    logic                    w_load;
    logic [N-1:0]            w_sign;
    logic [N*WBITS-1:0]      w_mag;
    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0]            act_sign;
    logic [N-1:0]            act_bit;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] h_sum;
    logic                    len_err;
    logic                    busy;

    modport master (
        output w_load, w_sign, w_mag, in_valid, act_sign, act_bit, in_last, out_ready,
        input  in_ready, out_valid, h_sum, len_err, busy
    );

    modport slave (
        input  w_load, w_sign, w_mag, in_valid, act_sign, act_bit, in_last, out_ready,
        output in_ready, out_valid, h_sum, len_err, busy
    );
endinterface

// File: rtl/popcount_mac_serial.sv
// Bit-serial weight-stationary signed dot product: per-plane signed popcounts,
// shift-accumulated MSB first. Define POPMAC_SAT_EN to saturate instead of wrap.
//
//   state | meaning
//   IDLE  | waiting for weights or the first beat of a vector
//   ACCUM | vector in flight, accepting bit-planes
//   FLUSH | last partial draining into the accumulator
//   HOLD  | result presented until out_ready
module popcount_mac_serial #(
    parameter int N     = 32,
    parameter int WBITS = 3,
    parameter int ABITS = 8,
    parameter int ACC_W = 18
) (
    input logic                 clk,
    input logic                 rst_n,
    popcount_mac_serial_if.slave bus
);
    localparam int PW = $clog2(N * ((1 << WBITS) - 1) + 1) + 1;
    localparam int CW = $clog2(N + 1);
    localparam int BW = (ABITS > 1) ? $clog2(ABITS) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;
    state_t state, state_nxt;

    logic [N-1:0]            w_sign_q;
    logic [N*WBITS-1:0]      w_mag_q;
    logic [N-1:0]            act_sign_q;
    logic [N-1:0]            eff_sign;
    logic [BW-1:0]           beat_cnt;
    logic [CW-1:0]           plus_k, minus_k;
    logic signed [PW-1:0]    p_comb, p_q;
    logic                    p_vld, p_first;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic                    len_err_q;
    logic                    ready, accept, first_beat, len_hit, last_beat;

    assign ready      = (state == ACCUM) || (state == IDLE && !bus.w_load);
    assign accept     = bus.in_valid && ready;
    assign first_beat = (state == IDLE);
    assign len_hit    = (beat_cnt == BW'(ABITS - 1));
    assign last_beat  = bus.in_last || len_hit;
    // Sign only travels with beat 0; later beats reuse the captured copy.
    assign eff_sign   = first_beat ? bus.act_sign : act_sign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = last_beat ? FLUSH : ACCUM;
            ACCUM:   if (accept && last_beat) state_nxt = FLUSH;
            FLUSH:   state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        plus_k  = '0;
        minus_k = '0;
        p_comb  = '0;
        for (int k = 0; k < WBITS; k++) begin
            plus_k  = '0;
            minus_k = '0;
            for (int i = 0; i < N; i++) begin
                if (bus.act_bit[i] && w_mag_q[i*WBITS + k]) begin
                    if (eff_sign[i] ^ w_sign_q[i]) minus_k = minus_k + CW'(1);
                    else                           plus_k  = plus_k + CW'(1);
                end
            end
            p_comb = p_comb + ((PW'(plus_k) - PW'(minus_k)) << k);
        end
    end

`ifdef POPMAC_SAT_EN
    localparam logic signed [ACC_W+1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W+1:0] acc_wide;

    always_comb begin
        acc_wide = p_first ? '0 : {acc[ACC_W-1], acc, 1'b0};
        acc_wide = acc_wide + {{(ACC_W+2-PW){p_q[PW-1]}}, p_q};
        if (acc_wide > SAT_MAX)      acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
        else if (acc_wide < SAT_MIN) acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
        else                         acc_nxt = acc_wide[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_nxt = (p_first ? '0 : {acc[ACC_W-2:0], 1'b0}) + {{(ACC_W-PW){p_q[PW-1]}}, p_q};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_sign_q   <= '0;
            w_mag_q    <= '0;
            act_sign_q <= '0;
            beat_cnt   <= '0;
            p_q        <= '0;
            p_vld      <= 1'b0;
            p_first    <= 1'b0;
            acc        <= '0;
            len_err_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.w_load) begin
                w_sign_q <= bus.w_sign;
                w_mag_q  <= bus.w_mag;
            end
            if (accept && first_beat) act_sign_q <= bus.act_sign;
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
                p_q      <= p_comb;
                p_first  <= first_beat;
            end
            if (accept && len_hit && !bus.in_last) len_err_q <= 1'b1;
            p_vld <= accept;
            if (p_vld) acc <= acc_nxt;
        end
    end

    // Gate with rst_n so the streamer sees no ready while reset is held.
    assign bus.in_ready  = rst_n && ready;
    assign bus.out_valid = (state == HOLD);
    assign bus.h_sum     = acc;
    assign bus.len_err   = len_err_q;
    assign bus.busy      = (state != IDLE);
endmodule
